brick_store_param: RTL
======================

// Module: brick_store_param
// PURPOSE
//  Parametrised brick-field storage for breakout: holds NUM_BRICKS brick records in an internal RAM.
//  After reset or reload, generates the grid layout, then serves one read/delete request at a time.
//  Requests come from the collider/display/control FSMs through a valid/ready handshake.
//  Tracks the live-brick count.
//  Successor to the fixed 64x19-bit store: parametrised geometry, reload, error flag, optional multi-hit bricks.
// PARAMETERS
//  NUM_BRICKS  64  number of records (1..2**ADDR_W)
//  ADDR_W      6   address width
//  COLS        8   bricks per row in generated layout
//  X_W         8   x-coordinate field width
//  Y_W         7   y-coordinate field width
//  COLOUR_W    3   colour field width
//  HP_W        2   hit-point field width (present in record even if HITPOINTS_EN undefined)
//  X0, Y0      8, 10    pixel origin of brick (0,0)
//  PIX_W,PIX_H 16, 6    brick pitch in pixels
//  HP_INIT     2   initial hit points per brick (HITPOINTS_EN only; else field loads 1)
//  BRICK_W = 1+HP_W+COLOUR_W+Y_W+X_W (derived localparam); record = {alive,hp,colour,y,x}
// PORTS
//  clock        in   1        system clock, all logic on posedge
//  resetn       in   1        async active-low reset
//  reload       in   1        pulse: regenerate full field (accepted only when ready=1)
//  req_valid    in   1        request present
//  req_delete   in   1        1=delete (hit) brick, 0=read only; sampled with req_valid
//  req_addr     in   ADDR_W   brick index
//  ready        out  1        store idle and accepting requests
//  done_loading out  1        1 once layout generation complete; 0 during INIT
//  rsp_valid    out  1        one-cycle pulse, brick_out/rsp_err valid
//  rsp_err      out  1        request addressed index >= NUM_BRICKS
//  brick_out    out  BRICK_W  record read (pre-update value for delete); held until next rsp
//  brick_count  out  ADDR_W+1 number of records with alive=1
// BEHAVIOUR
//  Reset: state INIT, index 0; ready=0, done_loading=0, rsp_valid=0, rsp_err=0, brick_out=0, brick_count=0.
//  FSM INIT -> IDLE -> RD -> RSP -> IDLE.
//  INIT: one RAM write per cycle, index i = 0..NUM_BRICKS-1 (NUM_BRICKS cycles).
//   col/row counters, no divider: x=X0+col*PIX_W, y=Y0+row*PIX_H, colour=row[COLOUR_W-1:0], alive=1.
//   Fields truncated to width. Last write: brick_count<=NUM_BRICKS, done_loading<=1, go IDLE.
//  IDLE: ready=1. reload=1 has priority over req_valid: done_loading<=0, go INIT (count kept until end of INIT).
//   Otherwise req_valid=1: latch addr/op, ready<=0, go RD. Requests with ready=0 are ignored, never queued.
//  RD: synchronous RAM read of latched addr (1-cycle RAM latency).
//  RSP: rsp_valid=1 for exactly one cycle; brick_out=record read; back to IDLE.
//   Handshake latency: accept edge T, rsp_valid high in cycle T+2, ready high again in T+3.
//  Delete on live brick: write-back in RSP cycle (see CONFIGURATION); brick_count-1 only when alive goes 1->0.
//  Delete on dead brick: no write, count unchanged, brick_out shows alive=0.
//  addr >= NUM_BRICKS: no RAM access/write, rsp_err=1, brick_out=0, same latency.
//   rsp_err cleared on next rsp.
//  brick_count never underflows; equals popcount(alive) at all times in IDLE.
//  Reset asserted mid-operation: immediate abort, any pending write dropped, INIT restarts from index 0.
// CONFIGURATION
//  BRICK_STORE_HITPOINTS_EN defined:
//   INIT loads hp=HP_INIT. Delete on live brick with hp>1 writes hp-1, alive stays 1.
//   Delete on live brick with hp<=1 writes hp=0, alive=0, count-1.
//  Undefined: INIT loads hp=1. Any delete on live brick writes alive=0, hp=0, count-1.
// TESTING
//  Reset then run: done_loading rises after exactly 64 clocks; brick_count=64; ready=1.
//  Read addr 9 (defaults): rsp_valid at T+2; brick_out={1,hp,3'd1,7'd16,8'd24}; rsp_err=0.
//  Delete addr 5, no macro: brick_count 64->63; re-read shows alive=0; second delete leaves count 63.
//  BRICK_STORE_HITPOINTS_EN, HP_INIT=2: first delete on addr 5 -> hp=1, count 64.
//   Second delete -> alive=0, count 63.
//  req_addr=6'd63 with NUM_BRICKS=40: rsp_err=1, brick_out=0, count unchanged.
//  reload with req_valid in same IDLE cycle: req ignored, done_loading=0, full field restored, count=NUM_BRICKS.
//  resetn pulsed during RD of a delete: no count change, INIT restarts, final count=NUM_BRICKS.

Source files
------------

// File: rtl/brick_store_param.sv
// Brick-field RAM for breakout: grid generation, read/delete service, live count.
// Optional multi-hit bricks when BRICK_STORE_HITPOINTS_EN is defined.
module brick_store_param #(
  parameter int NUM_BRICKS = 64,
  parameter int ADDR_W = 6,
  parameter int COLS = 8,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COLOUR_W = 3,
  parameter int HP_W = 2,
  parameter int X0 = 8,
  parameter int Y0 = 10,
  parameter int PIX_W = 16,
`ifdef BRICK_STORE_HITPOINTS_EN
  parameter int HP_INIT = 2,
`endif
  parameter int PIX_H = 6,
  localparam int BRICK_W = 1 + HP_W + COLOUR_W + Y_W + X_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                reload,
  input  logic                req_valid,
  input  logic                req_delete,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                ready,
  output logic                done_loading,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [BRICK_W-1:0]  brick_out,
  output logic [ADDR_W:0]     brick_count
);

  localparam int BODY_W = COLOUR_W + Y_W + X_W;

  localparam logic [ADDR_W:0]   NB       = (ADDR_W+1)'(NUM_BRICKS);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_BRICKS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COL_LAST = (ADDR_W+1)'(COLS - 1);
  localparam logic [ADDR_W:0]   COL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [COLOUR_W-1:0] ROW_ONE = COLOUR_W'(1);
  localparam logic [X_W-1:0]    X0_V     = X_W'(X0);
  localparam logic [Y_W-1:0]    Y0_V     = Y_W'(Y0);
  localparam logic [X_W-1:0]    PW_V     = X_W'(PIX_W);
  localparam logic [Y_W-1:0]    PH_V     = Y_W'(PIX_H);
`ifdef BRICK_STORE_HITPOINTS_EN
  localparam logic [HP_W-1:0]   HP_LOAD  = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]   HP_ONE   = HP_W'(1);
`else
  localparam logic [HP_W-1:0]   HP_LOAD  = HP_W'(1);
`endif

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD,
    RSP
  } state_t;

  state_t                state;
  logic [ADDR_W-1:0]     idx;
  logic [ADDR_W-1:0]     addr_q;
  logic                  del_q;
  logic                  err_q;
  logic [ADDR_W:0]       col;
  logic [COLOUR_W-1:0]   row;
  logic [X_W-1:0]        x_acc;
  logic [Y_W-1:0]        y_acc;
  logic [BRICK_W-1:0]    rd_data;
  logic [BRICK_W-1:0]    mem [NUM_BRICKS];

  logic                  init_we;
  logic                  hit_we;
  logic                  kill;
  logic                  rd_alive;
  logic [BODY_W-1:0]     rd_body;
  logic [BRICK_W-1:0]    init_rec;
  logic [BRICK_W-1:0]    hit_rec;

  assign rd_alive = rd_data[BRICK_W-1];
  assign rd_body  = rd_data[BODY_W-1:0];
  assign init_rec = {1'b1, HP_LOAD, row, y_acc, x_acc};

  // writes are gated by resetn so an abort never lands a stale write-back
  assign init_we = resetn && (state == INIT);
  assign hit_we  = resetn && (state == RSP) && del_q
                   && !err_q && rd_alive;

`ifdef BRICK_STORE_HITPOINTS_EN
  logic [HP_W-1:0] rd_hp;
  assign rd_hp = rd_data[BRICK_W-2 -: HP_W];

  always_comb begin
    hit_rec = {1'b0, {HP_W{1'b0}}, rd_body};
    kill    = 1'b1;
    if (rd_hp > HP_ONE) begin
      hit_rec = {1'b1, rd_hp - HP_ONE, rd_body};
      kill    = 1'b0;
    end
  end
`else
  always_comb begin
    hit_rec = {1'b0, {HP_W{1'b0}}, rd_body};
    kill    = 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (init_we) begin
      mem[idx] <= init_rec;
    end else if (hit_we) begin
      mem[addr_q] <= hit_rec;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= INIT;
      idx          <= '0;
      col          <= '0;
      row          <= '0;
      x_acc        <= X0_V;
      y_acc        <= Y0_V;
      addr_q       <= '0;
      del_q        <= 1'b0;
      err_q        <= 1'b0;
      rd_data      <= '0;
      ready        <= 1'b0;
      done_loading <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      brick_out    <= '0;
      brick_count  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        INIT: begin
          idx <= idx + IDX_ONE;
          // running sums replace col*PIX_W and row*PIX_H
          if (col == COL_LAST) begin
            col   <= '0;
            x_acc <= X0_V;
            row   <= row + ROW_ONE;
            y_acc <= y_acc + PH_V;
          end else begin
            col   <= col + COL_ONE;
            x_acc <= x_acc + PW_V;
          end
          if (idx == LAST) begin
            brick_count  <= NB;
            done_loading <= 1'b1;
            ready        <= 1'b1;
            state        <= IDLE;
          end
        end
        IDLE: begin
          if (!ready) begin
            ready <= 1'b1;
          end else if (reload) begin
            ready        <= 1'b0;
            done_loading <= 1'b0;
            idx          <= '0;
            col          <= '0;
            row          <= '0;
            x_acc        <= X0_V;
            y_acc        <= Y0_V;
            state        <= INIT;
          end else if (req_valid) begin
            ready  <= 1'b0;
            addr_q <= req_addr;
            del_q  <= req_delete;
            err_q  <= ({1'b0, req_addr} >= NB);
            state  <= RD;
          end
        end
        RD: begin
          if (!err_q) begin
            rd_data <= mem[addr_q];
          end
          state <= RSP;
        end
        RSP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          brick_out <= err_q ? '0 : rd_data;
          if (hit_we && kill && (brick_count != '0)) begin
            brick_count <= brick_count - CNT_ONE;
          end
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
